// File: rtl/usb_tx_encoder.sv
// usb_tx_encoder: full-speed USB transmitter with SYNC, bit stuffing, NRZI and EOP
`timescale 1ns/1ps
module usb_tx_encoder #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_error,
  output logic       d_plus_out,
  output logic       d_minus_out,
  output logic       transmitting
);
  localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP_SE0, EOP_J} state_t;
  state_t state, state_n;
  logic [TW-1:0] tick, tick_n;
  logic [2:0] cnt, cnt_n, ones, ones_n;
  logic [7:0] sh, sh_n, hold, hold_n;
  logic sh_last, sh_last_n, hold_last, hold_last_n, hold_full, hold_full_n;
  logic level, level_n, se0, se0_n, drive, drive_n;
  logic bnd, stuff, accept, emit, bit_v;
  assign bnd = tick == TW'(CLKS_PER_BIT - 1);
  assign stuff = ones == 3'd6;
  assign tx_ready = !rst && !hold_full && (state inside {IDLE, SYNC, DATA});
  assign accept = tx_valid && tx_ready;
  assign tx_busy = state != IDLE;
  assign tx_error = state == DATA && bnd && !stuff && cnt == 3'd7 && !sh_last && !hold_full;
  assign d_plus_out = level && !se0;
  assign d_minus_out = !level && !se0;
  assign transmitting = drive;
  // state, shifter, holding register and registered line levels
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      tick <= '0;
      cnt <= '0;
      ones <= '0;
      sh <= '0;
      hold <= '0;
      sh_last <= 1'b0;
      hold_last <= 1'b0;
      hold_full <= 1'b0;
      level <= 1'b1;
      se0 <= 1'b0;
      drive <= 1'b0;
    end else begin
      state <= state_n;
      tick <= tick_n;
      cnt <= cnt_n;
      ones <= ones_n;
      sh <= sh_n;
      hold <= hold_n;
      sh_last <= sh_last_n;
      hold_last <= hold_last_n;
      hold_full <= hold_full_n;
      level <= level_n;
      se0 <= se0_n;
      drive <= drive_n;
    end
  end
  // next-state: picks the bit for the coming bit time, then applies NRZI and stuff counting
  always_comb begin
    state_n = state;
    tick_n = bnd ? '0 : tick + 1'b1;
    cnt_n = cnt;
    ones_n = ones;
    sh_n = sh;
    sh_last_n = sh_last;
    hold_n = hold;
    hold_last_n = hold_last;
    hold_full_n = hold_full;
    level_n = level;
    se0_n = se0;
    drive_n = drive;
    emit = 1'b0;
    bit_v = 1'b0;
    if (accept) begin
      hold_n = tx_data;
      hold_last_n = tx_last;
      hold_full_n = 1'b1;
    end
    case (state)
      IDLE: begin
        tick_n = '0;
        if (hold_full || accept) begin
          state_n = SYNC;
          cnt_n = '0;
          drive_n = 1'b1;
          emit = 1'b1;
        end
      end
      SYNC: if (bnd) begin
        emit = 1'b1;
        if (cnt == 3'd7) begin
          state_n = DATA;
          sh_n = hold;
          sh_last_n = hold_last;
          hold_full_n = 1'b0;
          bit_v = hold[0];
          cnt_n = '0;
        end else begin
          cnt_n = cnt + 3'd1;
          bit_v = cnt == 3'd6;
        end
      end
      DATA: if (bnd) begin
        emit = 1'b1;
        if (stuff) bit_v = 1'b0;
        else if (cnt != 3'd7) begin
          cnt_n = cnt + 3'd1;
          sh_n = sh >> 1;
          bit_v = sh[1];
        end else if (sh_last || !hold_full) begin
          state_n = EOP_SE0;
          emit = 1'b0;
          se0_n = 1'b1;
          cnt_n = '0;
          if (!sh_last) hold_full_n = 1'b0;
        end else begin
          sh_n = hold;
          sh_last_n = hold_last;
          hold_full_n = 1'b0;
          bit_v = hold[0];
          cnt_n = '0;
        end
      end
      EOP_SE0: if (bnd) begin
        cnt_n = cnt + 3'd1;
        if (cnt == 3'd1) begin
          state_n = EOP_J;
          se0_n = 1'b0;
          level_n = 1'b1;
        end
      end
      EOP_J: if (bnd) begin
        state_n = IDLE;
        drive_n = 1'b0;
        ones_n = '0;
        level_n = 1'b1;
      end
      default: state_n = IDLE;
    endcase
    if (emit) begin
      level_n = bit_v ? level : !level;
      ones_n = bit_v ? ones + 3'd1 : 3'd0;
    end
  end
endmodule

// File: tb/tb_usb_tx_encoder.sv
// tb_usb_tx_encoder: directed checks of line stream, timing and handshake of usb_tx_encoder
`timescale 1ns/1ps
module tb_usb_tx_encoder;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] tx_data = '0;
  logic tx_valid = 1'b0, tx_last = 1'b0;
  logic tx_ready, tx_busy, tx_error, d_plus_out, d_minus_out, transmitting;
  int checks = 0, errors = 0;
  logic [1:0] q[$];
  int err_cnt = 0, err_idx = -1, bad_rdy = 0, low_run = 0, last_gap = -1;
  logic prev_tx = 1'b0, in_eop = 1'b0;

  usb_tx_encoder #(.CLKS_PER_BIT(8)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
    .tx_ready(tx_ready), .tx_busy(tx_busy), .tx_error(tx_error),
    .d_plus_out(d_plus_out), .d_minus_out(d_minus_out), .transmitting(transmitting)
  );

  always #5 clk = ~clk;

  // records the driven line per cycle, error pulses, idle gaps and ready during EOP
  always @(negedge clk) begin
    if (tx_error === 1'b1) begin
      err_cnt++;
      err_idx = q.size();
    end
    if (transmitting === 1'b1 && !prev_tx) last_gap = low_run;
    low_run = (transmitting === 1'b1) ? 0 : low_run + 1;
    prev_tx = transmitting === 1'b1;
    if (transmitting === 1'b1) q.push_back({d_plus_out, d_minus_out});
    if (transmitting === 1'b1 && {d_plus_out, d_minus_out} == 2'b00) in_eop = 1'b1;
    if (transmitting !== 1'b1) in_eop = 1'b0;
    if (in_eop && tx_ready === 1'b1) bad_rdy++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] sym(input byte c);
    return (c == "J") ? 2'b10 : (c == "K") ? 2'b01 : 2'b00;
  endfunction

  task automatic chk_stream(input string tag, input string s);
    logic [1:0] v;
    chk({tag, " len"}, q.size(), s.len() * 8);
    for (int i = 0; i < s.len(); i++) begin
      v = (i * 8 + 7 < q.size()) ? q[i * 8] : 2'b11;
      for (int c = 1; c < 8; c++)
        if (i * 8 + c < q.size() && q[i * 8 + c] !== v) v = 2'b11;
      chk($sformatf("%s bit%0d", tag, i), v, sym(s[i]));
    end
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    tx_data = d;
    tx_last = l;
    tx_valid = 1'b1;
    for (int i = 0; i < 1000 && tx_ready !== 1'b1; i++) @(negedge clk);
    chk("send ready", tx_ready, 1);
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 1000 && tx_ready !== 1'b1; i++) @(negedge clk);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 5000 && tx_busy !== 1'b0; i++) @(negedge clk);
    chk("idle timeout", tx_busy, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst dp", d_plus_out, 1);
    chk("rst dm", d_minus_out, 0);
    chk("rst transmitting", transmitting, 0);
    chk("rst ready", tx_ready, 0);
    chk("rst busy", tx_busy, 0);
    chk("rst error", tx_error, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle line", {d_plus_out, d_minus_out}, 2'b10);
    chk("idle transmitting", transmitting, 0);
    chk("idle ready", tx_ready, 1);
    chk("idle busy", tx_busy, 0);
    q.delete();
    err_cnt = 0;
    send(8'h00, 1'b1);
    chk("start transmitting", transmitting, 1);
    chk("start K", {d_plus_out, d_minus_out}, 2'b01);
    wait_idle();
    chk_stream("p00", "KJKJKJKKJKJKJKJK00J");
    chk("p00 err", err_cnt, 0);
    q.delete();
    send(8'hFF, 1'b1);
    wait_idle();
    chk_stream("pFF", "KJKJKJKKKKKKKJJJJ00J");
    chk("pFF err", err_cnt, 0);
    q.delete();
    send(8'hA5, 1'b0);
    wait_ready();
    repeat (4) @(negedge clk);
    send(8'hC3, 1'b0);
    wait_ready();
    repeat (4) @(negedge clk);
    send(8'h3C, 1'b1);
    wait_idle();
    chk_stream("multi", "KJKJKJKKKJJKJJKKKKJKJKKKJKKKKKJK00J");
    chk("multi err", err_cnt, 0);
    q.delete();
    send(8'h00, 1'b0);
    wait_idle();
    chk_stream("underrun", "KJKJKJKKJKJKJKJK00J");
    chk("underrun pulses", err_cnt, 1);
    chk("underrun at", err_idx, 127);
    q.delete();
    err_cnt = 0;
    send(8'h00, 1'b1);
    wait_idle();
    send(8'hFF, 1'b1);
    wait_idle();
    chk_stream("b2b", "KJKJKJKKJKJKJKJK00JKJKJKJKKKKKKKJJJJ00J");
    chk("b2b gap", last_gap, 1);
    chk("eop ready", bad_rdy, 0);
    chk("b2b err", err_cnt, 0);
    send(8'hA5, 1'b1);
    repeat (100) @(negedge clk);
    chk("mid busy", tx_busy, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort line", {d_plus_out, d_minus_out}, 2'b10);
    chk("abort transmitting", transmitting, 0);
    chk("abort busy", tx_busy, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort ready", tx_ready, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
